ag_sram_arbiter: RTL and testbench
==================================

Name: ag_sram_arbiter

Overview:
- Shares one asynchronous 32Kx8 SRAM between the CPU bus (byte read/write) and the video fetcher (16-bit word reads).
- Replaces the dual-port base RAM in the Agat top level.
- Runs on clk50 and sequences SRAM strobes and wait states.
- Video has fixed priority; a starvation guard bounds CPU wait time.

Parameters:
- WAIT_STATES, 1, extra clk50 cycles per SRAM byte access, legal range 0..7.
- MAX_CPU_WAIT, 8, number of pending cycles after which CPU beats video at arbitration, legal range 1..255.

Ports:
- clk50  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request, level.
- cpu_we  in  1  1=write, 0=read; valid while cpu_req.
- cpu_addr  in  15  CPU byte address.
- cpu_wdata  in  8  write data.
- cpu_rdata  out  8  read data; valid while cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- vid_req  in  1  video word request, level.
- vid_addr  in  14  video word address.
- vid_data  out  16  {odd byte, even byte}; valid while vid_ack.
- vid_ack  out  1  one-cycle completion pulse.
- sram_addr  out  15  SRAM address.
- sram_ce_n  out  1  chip enable.
- sram_oe_n  out  1  output enable.
- sram_we_n  out  1  write enable.
- sram_dout  out  8  data to SRAM.
- sram_din  in  8  data from SRAM.
- sram_dq_oe  out  1  tristate drive enable for sram_dout.

Behaviour:
- Reset state (async, immediate): state=IDLE, sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dout=0, cpu_rdata=0, vid_data=0, cpu_ack=0, vid_ack=0, starve counter=0.
- Reset mid-access: the access is abandoned and no ack is issued.
- All outputs are registered. W means WAIT_STATES.
- States: IDLE, CPU_RD, CPU_WR_SETUP, CPU_WR_PULSE, CPU_WR_HOLD, VID_LO, VID_HI.
- Arbitration happens only in IDLE:
  - If cpu_req and starve counter >= MAX_CPU_WAIT, grant CPU.
  - Else if vid_req, grant video.
  - Else if cpu_req, grant CPU.
  - Else stay in IDLE with ce_n=1.
- Starve counter:
  - Increments, saturating at 255, each cycle cpu_req=1 and the CPU is not granted.
  - Clears on CPU grant.
  - Clears when cpu_req=0.
- Inputs are captured at grant. Later changes to addr, data or we have no effect on the access in flight.
- CPU_RD:
  - ce_n=0, oe_n=0, addr=cpu_addr for W+1 cycles.
  - sram_din is latched on the last of those edges.
  - Next cycle: cpu_ack=1 with cpu_rdata, state back in IDLE.
  - Latency from grant edge to ack high: W+2 cycles.
- CPU write:
  - SETUP, 1 cycle: ce_n=0, dq_oe=1, dout=wdata, we_n=1.
  - PULSE, W+1 cycles: we_n=0.
  - HOLD, 1 cycle: we_n=1, dq_oe stays 1.
  - Then cpu_ack=1 in the next cycle with dq_oe=0.
  - Latency W+4.
  - oe_n stays 1 throughout the write.
  - dq_oe never overlaps oe_n=0.
- Video access:
  - VID_LO reads address {vid_addr,0} for W+1 cycles.
  - VID_HI immediately reads {vid_addr,1} for W+1 cycles; ce_n and oe_n stay low with no idle gap.
  - Then vid_ack=1 with vid_data={hi,lo}.
  - Latency 2W+3.
- Handshake:
  - ack pulses for exactly one cycle, in the cycle the FSM is in IDLE.
  - A requester that does not want another access must deassert req on the edge that samples ack=1.
  - A req still high in the ack cycle is treated as a new request; arbitration that cycle uses the new addr/we.
  - Back-to-back accesses therefore carry no dead cycle beyond the ack cycle.
- Simultaneous requests: rules above apply; video wins unless starvation triggers.
- Worst-case CPU wait: MAX_CPU_WAIT cycles plus one video access.
- Address wrap: vid_addr=3FFF gives byte addresses 7FFE and 7FFF, with no carry.
- Never both cpu_ack and vid_ack in the same cycle.

Test Plan:
- Reset, then W=1, cpu write 0x5A to 0x1234 → we_n low exactly 2 cycles, dq_oe=1 for 4 cycles, cpu_ack 5 cycles after grant. Then read 0x1234 → cpu_rdata=0x5A, ack 3 cycles after grant.
- Video read vid_addr=0x0800 with SRAM[0x1000]=0x11, [0x1001]=0x22 → vid_data=0x2211, vid_ack 5 cycles after grant, ce_n continuous low.
- vid_req and cpu_req both raised in the same cycle, video re-requesting continuously with MAX_CPU_WAIT=8 → first grant to video; CPU granted once its counter reaches 8; cpu_ack then arrives.
- vid_addr=0x3FFF → SRAM addresses 0x7FFE then 0x7FFF, no wrap to 0.
- rst_n pulled low during VID_HI → strobes deasserted the same instant, no vid_ack. After release, IDLE and a fresh cpu read completes normally.
- Random back-to-back CPU/video traffic against a reference memory model → all read data match, dq_oe and oe_n never both active, acks never coincide.

Source files
------------

// File: rtl/ag_sram_arbiter.sv
// ag_sram_arbiter: one async 32Kx8 SRAM shared by CPU bytes and
// video 16-bit word fetches; video has priority, a starve guard bounds CPU wait.
module ag_sram_arbiter #(
  parameter int WAIT_STATES  = 1,
  parameter int MAX_CPU_WAIT = 8
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic [13:0] vid_addr,
  output logic [15:0] vid_data,
  output logic        vid_ack,
  output logic [14:0] sram_addr,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [7:0]  sram_dout,
  input  logic [7:0]  sram_din,
  output logic        sram_dq_oe
);

  typedef enum logic [2:0] {
    IDLE,
    CPU_RD,
    CPU_WR_SETUP,
    CPU_WR_PULSE,
    CPU_WR_HOLD,
    VID_LO,
    VID_HI
  } state_t;

  localparam logic [2:0] W    = 3'(WAIT_STATES);
  localparam logic [7:0] MAXW = 8'(MAX_CPU_WAIT);

  state_t      state;
  logic [2:0]  cnt;
  logic [7:0]  starve;
  logic [7:0]  lo_q;
  logic        cpu_pick;
  logic        vid_pick;
  logic        cpu_busy;
  logic        cnt_done;

  // Arbitration decision, only taken while the FSM sits in IDLE
  always_comb begin
    cpu_pick = 1'b0;
    vid_pick = 1'b0;
    if (state == IDLE) begin
      if (cpu_req && (starve >= MAXW))
        cpu_pick = 1'b1;
      else if (vid_req)
        vid_pick = 1'b1;
      else if (cpu_req)
        cpu_pick = 1'b1;
    end
    cpu_busy = (state == CPU_RD)       ||
               (state == CPU_WR_SETUP) ||
               (state == CPU_WR_PULSE) ||
               (state == CPU_WR_HOLD);
    cnt_done = (cnt == W);
  end

  // Starve counter: counts cycles the CPU waits, cleared on grant or idle
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n)
      starve <= '0;
    else if (!cpu_req || cpu_pick)
      starve <= '0;
    else if (!cpu_busy && (starve != 8'hFF))
      starve <= starve + 8'd1;
  end

  // Access sequencer with registered SRAM strobes and acks
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      lo_q       <= '0;
      sram_addr  <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_dout  <= '0;
      sram_dq_oe <= 1'b0;
      cpu_rdata  <= '0;
      cpu_ack    <= 1'b0;
      vid_data   <= '0;
      vid_ack    <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (cpu_pick) begin
            sram_addr <= cpu_addr;
            sram_ce_n <= 1'b0;
            if (cpu_we) begin
              sram_dout  <= cpu_wdata;
              sram_dq_oe <= 1'b1;
              state      <= CPU_WR_SETUP;
            end else begin
              sram_oe_n <= 1'b0;
              state     <= CPU_RD;
            end
          end else if (vid_pick) begin
            sram_addr <= {vid_addr, 1'b0};
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b0;
            state     <= VID_LO;
          end
        end
        CPU_RD: begin
          if (cnt_done) begin
            cpu_rdata <= sram_din;
            cpu_ack   <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        CPU_WR_SETUP: begin
          sram_we_n <= 1'b0;
          cnt       <= '0;
          state     <= CPU_WR_PULSE;
        end
        CPU_WR_PULSE: begin
          if (cnt_done) begin
            sram_we_n <= 1'b1;
            state     <= CPU_WR_HOLD;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        CPU_WR_HOLD: begin
          sram_dq_oe <= 1'b0;
          sram_ce_n  <= 1'b1;
          cpu_ack    <= 1'b1;
          state      <= IDLE;
        end
        VID_LO: begin
          if (cnt_done) begin
            lo_q         <= sram_din;
            sram_addr[0] <= 1'b1;
            cnt          <= '0;
            state        <= VID_HI;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        VID_HI: begin
          if (cnt_done) begin
            vid_data  <= {sram_din, lo_q};
            vid_ack   <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: begin
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ag_sram_arbiter.sv
// tb_ag_sram_arbiter: scoreboard bench for the SRAM arbiter
// with an async SRAM model and directed plus random traffic.
module tb_ag_sram_arbiter;

  localparam int W    = 1;
  localparam int MAXW = 8;

  logic        clk50 = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        vid_req;
  logic [13:0] vid_addr;
  logic [15:0] vid_data;
  logic        vid_ack;
  logic [14:0] sram_addr;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [7:0]  sram_dout;
  logic [7:0]  sram_din;
  logic        sram_dq_oe;

  logic [7:0]  mem     [0:32767];
  logic [7:0]  ref_mem [0:32767];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [8:0]  cpu_q [$];
  logic [15:0] vid_q [$];

  int start_cyc = 0;
  int ce_low = 0;
  int we_low = 0;
  int dq_cnt = 0;
  int lat_cpu = 0;
  int lat_vid = 0;
  int vid_ack_cnt = 0;
  int ovl_cnt = 0;
  int both_cnt = 0;
  logic [14:0] addr_first = '0;
  logic [14:0] addr_last = '0;
  logic [15:0] vid_last = '0;
  logic        ce_prev = 1'b1;

  ag_sram_arbiter #(
    .WAIT_STATES (W),
    .MAX_CPU_WAIT(MAXW)
  ) dut (
    .clk50     (clk50),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .vid_ack   (vid_ack),
    .sram_addr (sram_addr),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .sram_dout (sram_dout),
    .sram_din  (sram_din),
    .sram_dq_oe(sram_dq_oe)
  );

  always #5 clk50 = ~clk50;

  // cycle stamp
  always @(posedge clk50) cyc <= cyc + 1;

  // async SRAM: reads while ce/oe low, writes while we pulse is low
  assign sram_din = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 8'h00;

  always @(posedge clk50)
    if (!sram_ce_n && !sram_we_n && sram_dq_oe)
      mem[sram_addr] <= sram_dout;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // protocol monitor and scoreboard pop, away from the active edge
  always @(negedge clk50) begin
    logic [8:0] ce;
    logic [15:0] ve;
    if (!rst_n) begin
      ce_prev = 1'b1;
    end else begin
      if (!sram_oe_n && sram_dq_oe) ovl_cnt++;
      if (cpu_ack && vid_ack) both_cnt++;
      if (!sram_ce_n) begin
        if (ce_prev) begin
          start_cyc  = cyc;
          ce_low     = 0;
          we_low     = 0;
          dq_cnt     = 0;
          addr_first = sram_addr;
        end
        ce_low++;
        addr_last = sram_addr;
      end
      if (!sram_we_n) we_low++;
      if (sram_dq_oe) dq_cnt++;
      ce_prev = sram_ce_n;
      if (cpu_ack) begin
        lat_cpu = cyc - start_cyc + 1;
        if (cpu_q.size() == 0) begin
          check("cpu_spurious_ack", 1, 0);
        end else begin
          ce = cpu_q.pop_front();
          if (ce[8]) check("cpu_rdata", cpu_rdata, ce[7:0]);
        end
      end
      if (vid_ack) begin
        vid_ack_cnt++;
        lat_vid = cyc - start_cyc + 1;
        vid_last = vid_data;
        if (vid_q.size() == 0) begin
          check("vid_spurious_ack", 1, 0);
        end else begin
          ve = vid_q.pop_front();
          check("vid_data", vid_data, ve);
        end
      end
    end
  end

  task automatic cpu_access(input logic we,
                            input logic [14:0] a,
                            input logic [7:0] d);
    int n;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    if (we) begin
      ref_mem[a] = d;
      cpu_q.push_back({1'b0, d});
    end else begin
      cpu_q.push_back({1'b1, ref_mem[a]});
    end
    n = 0;
    do begin
      @(posedge clk50); #1;
      n++;
    end while (!cpu_ack && n < 100);
    check("cpu_ack_seen", cpu_ack, 1);
  endtask

  task automatic vid_access(input logic [13:0] a);
    int n;
    vid_req  = 1'b1;
    vid_addr = a;
    vid_q.push_back({ref_mem[{a, 1'b1}], ref_mem[{a, 1'b0}]});
    n = 0;
    do begin
      @(posedge clk50); #1;
      n++;
    end while (!vid_ack && n < 100);
    check("vid_ack_seen", vid_ack, 1);
  endtask

  task automatic settle();
    @(negedge clk50); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vbase;
    int vid_before;
    int n;
    logic starve_done;

    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    vid_req   = 1'b0;
    vid_addr  = '0;
    for (int i = 0; i < 32768; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end

    #12;
    check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
    check("rst_acks", {cpu_ack, vid_ack}, 0);
    check("rst_addr_dout", {sram_addr, sram_dout}, 0);
    check("rst_rdata", {cpu_rdata, vid_data}, 0);
    @(negedge clk50);
    rst_n = 1'b1;
    @(posedge clk50); #1;
    check("idle_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);

    // directed write then read back
    cpu_access(1'b1, 15'h1234, 8'h5A);
    cpu_req = 1'b0;
    settle();
    check("wr_we_low_cycles", we_low, W + 1);
    check("wr_dq_oe_cycles", dq_cnt, W + 3);
    check("wr_latency", lat_cpu, W + 4);
    check("wr_dq_off_at_ack", sram_dq_oe, 0);

    cpu_access(1'b0, 15'h1234, 8'h00);
    cpu_req = 1'b0;
    settle();
    check("rd_latency", lat_cpu, W + 2);
    check("rd_data_5a", cpu_rdata, 8'h5A);

    // video word read
    mem[15'h1000] = 8'h11; ref_mem[15'h1000] = 8'h11;
    mem[15'h1001] = 8'h22; ref_mem[15'h1001] = 8'h22;
    vid_access(14'h0800);
    vid_req = 1'b0;
    settle();
    check("vid_word_2211", vid_last, 16'h2211);
    check("vid_latency", lat_vid, 2 * W + 3);
    check("vid_ce_continuous", ce_low, 2 * W + 2);
    check("vid_addr_lo", addr_first, 15'h1000);

    // top-of-memory word, no carry into byte 0
    mem[15'h7FFE] = 8'hA5; ref_mem[15'h7FFE] = 8'hA5;
    mem[15'h7FFF] = 8'h3C; ref_mem[15'h7FFF] = 8'h3C;
    vid_access(14'h3FFF);
    vid_req = 1'b0;
    settle();
    check("wrap_addr_lo", addr_first, 15'h7FFE);
    check("wrap_addr_hi", addr_last, 15'h7FFF);
    check("wrap_word", vid_last, 16'h3CA5);

    // simultaneous requests, video re-requesting continuously
    starve_done = 1'b0;
    vbase = vid_ack_cnt;
    vid_before = 0;
    fork
      begin
        cpu_access(1'b0, 15'h1234, 8'h00);
        vid_before  = vid_ack_cnt - vbase;
        starve_done = 1'b1;
        cpu_req     = 1'b0;
      end
      begin
        while (!starve_done) vid_access(14'h0800);
        vid_req = 1'b0;
      end
    join
    check("starve_vid_grants_first", vid_before, 2);
    settle();

    // reset while in VID_HI
    vid_req  = 1'b1;
    vid_addr = 14'h0123;
    n = 0;
    do begin
      @(posedge clk50); #1;
      n++;
    end while (!(!sram_ce_n && sram_addr[0]) && n < 20);
    check("reached_vid_hi", {sram_ce_n, sram_addr[0]}, 2'b01);
    #2;
    rst_n   = 1'b0;
    vid_req = 1'b0;
    vbase   = vid_ack_cnt;
    #1;
    check("rst_mid_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
    check("rst_mid_ack", vid_ack, 0);
    repeat (2) @(posedge clk50);
    @(negedge clk50);
    rst_n = 1'b1;
    repeat (3) @(posedge clk50);
    #1;
    check("rst_mid_no_vid_ack", vid_ack_cnt - vbase, 0);

    cpu_access(1'b0, 15'h1000, 8'h00);
    cpu_req = 1'b0;
    settle();
    check("post_rst_rd_latency", lat_cpu, W + 2);
    check("post_rst_rd_data", cpu_rdata, 8'h11);

    // random back-to-back traffic
    fork
      begin
        logic        w;
        logic [14:0] a;
        for (int i = 0; i < 60; i++) begin
          w = 1'($urandom);
          a = w ? {1'b1, 14'($urandom)} : 15'($urandom);
          cpu_access(w, a, 8'($urandom));
          if ($urandom_range(0, 2) == 0) begin
            cpu_req = 1'b0;
            repeat ($urandom_range(1, 3)) begin
              @(posedge clk50); #1;
            end
          end
        end
        cpu_req = 1'b0;
      end
      begin
        for (int j = 0; j < 60; j++) begin
          vid_access({1'b0, 13'($urandom)});
          if ($urandom_range(0, 2) == 0) begin
            vid_req = 1'b0;
            repeat ($urandom_range(1, 4)) begin
              @(posedge clk50); #1;
            end
          end
        end
        vid_req = 1'b0;
      end
    join
    repeat (3) settle();

    check("dq_oe_oe_overlap", ovl_cnt, 0);
    check("ack_coincide", both_cnt, 0);
    check("cpu_q_drained", cpu_q.size(), 0);
    check("vid_q_drained", vid_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
